mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-ported, fixed-latency unified memory between the IF fetch port and the MEM-stage data port of the pipelined CPU.
- Sequences each access over MEM_LATENCY cycles and returns per-port ready pulses.
- Produces d_next_ready for the hazard unit and supports cancelling an in-flight fetch after an IF flush.
- Keeps contention counters for performance reporting.

Parameters:
WORD_SIZE, 16, data and address width
MEM_LATENCY, 2, cycles an access occupies the memory (legal range 1..15)
CNT_WIDTH, 16, width of each contention counter (saturating)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
i_read  in  1  fetch request, level; held until i_ready or i_cancel
i_address  in  WORD_SIZE  fetch address, stable while i_read is high
i_cancel  in  1  discard the fetch in flight or pending (IF flush)
i_ready  out  1  one-cycle pulse; i_data valid in that cycle
i_data  out  WORD_SIZE  fetched word
d_read  in  1  data load request, level
d_write  in  1  data store request, level
d_address  in  WORD_SIZE  data address
d_wdata  in  WORD_SIZE  store data
d_ready  out  1  one-cycle pulse on load or store completion
d_next_ready  out  1  high exactly one cycle before d_ready
d_rdata  out  WORD_SIZE  loaded word
m_read  out  1  memory read strobe
m_write  out  1  memory write strobe
m_address  out  WORD_SIZE  memory address
m_wdata  out  WORD_SIZE  memory write data
m_rdata  in  WORD_SIZE  memory read data, valid in the last cycle of an access
i_stall_cnt  out  CNT_WIDTH  cycles i_read waited while the memory served D
d_stall_cnt  out  CNT_WIDTH  cycles a D request waited while the memory served I

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. Down-counter cnt is log2-wide, enough to hold MEM_LATENCY-1. Flag drop marks a cancelled fetch.
- Reset: state IDLE, cnt 0, drop 0, both counters 0. All m_* outputs 0. i_ready, d_ready and d_next_ready are 0.
- Arbitration happens in IDLE, and also in the completion cycle of BUSY_*.
  - A D request (d_read or d_write) beats an I request.
  - In a completion cycle, the port that just completed is ignored. If it is still requesting in the next cycle, that is a new request. This gives alternation under continuous contention, so there is no starvation.
- Grant at edge T moves to BUSY_x with cnt = MEM_LATENCY-1. It registers m_address and either m_read, or m_write plus m_wdata. These stay stable for exactly MEM_LATENCY cycles.
- If d_read and d_write are both high, the request is treated as a store.
- BUSY_x with cnt > 0: cnt decrements each cycle.
- BUSY_x with cnt == 0 is the completion cycle:
  - x_ready = 1. For I, i_ready is suppressed if drop is set or i_cancel is high.
  - i_data / d_rdata = m_rdata (combinational pass-through). They are don't-care outside the ready cycle.
  - Next state is the new grant, or IDLE with m_* cleared. A back-to-back grant has no idle bubble.
- d_next_ready = 1 in BUSY_D when cnt == 1. If MEM_LATENCY == 1, d_next_ready = 1 in the cycle a D grant is decided, i.e. the cycle before the ready cycle.
- i_cancel:
  - In IDLE, or while I is pending but not granted: the request is ignored that cycle and no grant is made to I.
  - During BUSY_I: set drop. The memory access still runs to completion, because reads have no side effects and the port cannot abort.
  - drop clears on leaving BUSY_I.
- Stores are never cancellable.
- Counters:
  - i_stall_cnt increments when i_read && !i_cancel && the memory is not granted to I that cycle because of D.
  - d_stall_cnt increments symmetrically.
  - Both saturate at all-ones.
- Reset mid-access: returns to IDLE next edge, drops m_* strobes, and raises no ready. The requester re-issues after reset.
- Request deasserted mid-access (illegal except via i_cancel): the access still completes and the ready pulse is still issued.

Test Plan:
- MEM_LATENCY=2, i_read at 0x0010 from cycle 1, m_rdata=0xABCD -> m_read/m_address=0x0010 in cycles 2-3; i_ready=1 with i_data=0xABCD in cycle 3 only; i_stall_cnt=0.
- d_write to 0x0040 data 0x1234 and i_read to 0x0011 both raised in cycle 1 -> m_write cycles 2-3; d_next_ready in cycle 2; d_ready in cycle 3; m_read for 0x0011 in cycles 4-5; i_ready in cycle 5; i_stall_cnt=2.
- d_read and i_read held high continuously for 12 cycles -> grants alternate D,I,D,I with no IDLE cycle between accesses; each port's ready arrives every 4 cycles.
- i_read granted, i_cancel pulsed in the first BUSY_I cycle -> the access occupies 2 cycles; i_ready never asserts; a pending d_read is granted at the completion edge.
- reset asserted during BUSY_D cycle 1 -> next cycle all m_* are 0, d_ready/d_next_ready are 0, state IDLE; counters are 0.
- MEM_LATENCY=1 single d_read -> d_next_ready in the grant-decision cycle and d_ready the next cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares a single-ported, fixed-latency memory between the fetch (I) and data (D) ports.
// D wins ties. The port completing in a cycle is left out of that cycle's arbitration.
module mem_port_arbiter #(
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_read,
  input  logic [WORD_SIZE-1:0] i_address,
  input  logic                 i_cancel,
  output logic                 i_ready,
  output logic [WORD_SIZE-1:0] i_data,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [WORD_SIZE-1:0] d_address,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ready,
  output logic                 d_next_ready,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 m_read,
  output logic                 m_write,
  output logic [WORD_SIZE-1:0] m_address,
  output logic [WORD_SIZE-1:0] m_wdata,
  input  logic [WORD_SIZE-1:0] m_rdata,
  output logic [CNT_WIDTH-1:0] i_stall_cnt,
  output logic [CNT_WIDTH-1:0] d_stall_cnt
);

  localparam int unsigned CntW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 drop_q, drop_d;
  logic                 m_read_q, m_read_d;
  logic                 m_write_q, m_write_d;
  logic [WORD_SIZE-1:0] m_address_q, m_address_d;
  logic [WORD_SIZE-1:0] m_wdata_q, m_wdata_d;
  logic [CNT_WIDTH-1:0] i_stall_q, i_stall_d;
  logic [CNT_WIDTH-1:0] d_stall_q, d_stall_d;

  logic busy_i, busy_d, done, arb, d_req, d_ok, i_ok, grant_d, grant_i, i_wait, d_wait;

  assign busy_i = (state_q == StBusyI);
  assign busy_d = (state_q == StBusyD);
  assign done   = (busy_i || busy_d) && (cnt_q == '0);
  assign arb    = (state_q == StIdle) || done;
  assign d_req  = d_read || d_write;

  // The completing port is excluded so a persistent requester alternates with the other port.
  assign d_ok    = d_req && !(busy_d && done);
  assign i_ok    = i_read && !i_cancel && !(busy_i && done);
  assign grant_d = arb && d_ok;
  assign grant_i = arb && i_ok && !d_ok;

  assign i_wait = i_read && !i_cancel && !busy_i && !grant_i && (busy_d || grant_d);
  assign d_wait = d_req && !busy_d && !grant_d && (busy_i || grant_i);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drop_d      = drop_q;
    m_read_d    = m_read_q;
    m_write_d   = m_write_q;
    m_address_d = m_address_q;
    m_wdata_d   = m_wdata_q;
    if (grant_d) begin
      state_d     = StBusyD;
      cnt_d       = CntLoad;
      drop_d      = 1'b0;
      m_read_d    = !d_write;
      m_write_d   = d_write;
      m_address_d = d_address;
      m_wdata_d   = d_write ? d_wdata : '0;
    end else if (grant_i) begin
      state_d     = StBusyI;
      cnt_d       = CntLoad;
      drop_d      = 1'b0;
      m_read_d    = 1'b1;
      m_write_d   = 1'b0;
      m_address_d = i_address;
      m_wdata_d   = '0;
    end else if (arb) begin
      state_d     = StIdle;
      cnt_d       = '0;
      drop_d      = 1'b0;
      m_read_d    = 1'b0;
      m_write_d   = 1'b0;
      m_address_d = '0;
      m_wdata_d   = '0;
    end else begin
      cnt_d  = cnt_q - CntW'(1);
      // A flushed fetch keeps the memory busy until it finishes; only its ready is hidden.
      drop_d = drop_q || (busy_i && i_cancel);
    end
  end

  always_comb begin
    i_stall_d = i_stall_q;
    d_stall_d = d_stall_q;
    if (i_wait && (i_stall_q != '1)) i_stall_d = i_stall_q + CNT_WIDTH'(1);
    if (d_wait && (d_stall_q != '1)) d_stall_d = d_stall_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      drop_q      <= 1'b0;
      m_read_q    <= 1'b0;
      m_write_q   <= 1'b0;
      m_address_q <= '0;
      m_wdata_q   <= '0;
      i_stall_q   <= '0;
      d_stall_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
      m_read_q    <= m_read_d;
      m_write_q   <= m_write_d;
      m_address_q <= m_address_d;
      m_wdata_q   <= m_wdata_d;
      i_stall_q   <= i_stall_d;
      d_stall_q   <= d_stall_d;
    end
  end

  assign m_read      = m_read_q;
  assign m_write     = m_write_q;
  assign m_address   = m_address_q;
  assign m_wdata     = m_wdata_q;
  assign i_stall_cnt = i_stall_q;
  assign d_stall_cnt = d_stall_q;

  assign i_data  = m_rdata;
  assign d_rdata = m_rdata;

  // Ready pulses are masked during reset so an aborted access never reports completion.
  assign i_ready = busy_i && done && !drop_q && !i_cancel && !reset;
  assign d_ready = busy_d && done && !reset;
  assign d_next_ready = !reset &&
                        ((MEM_LATENCY == 1) ? grant_d : (busy_d && (cnt_q == CntW'(1))));

endmodule
